bf_exec_core: RTL and testbench

BF_EXEC_CORE -- requirements
Module: bf_exec_core

---
 rtl/bf_exec_core.sv | 214 +++++++++++++++++++++
 tb/tb_bf_exec_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf_exec_core.sv
// Brainfuck-style execution core: fetches from a combinational ROM, operates on a synchronous-read data RAM.
// Optional macro BF_CELL_SAT_EN makes INC/DEC saturate instead of wrap.
module bf_exec_core #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 8,
    parameter int unsigned PW     = 8,
    parameter int unsigned LDEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    output logic [PW-1:0] pc_o,
    input  logic [8:0]    instr_i,
    output logic [AW-1:0] mem_addr_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          done_o,
    output logic          error_o
);
    localparam int unsigned SW  = $clog2(LDEPTH + 1);
    localparam int unsigned SIW = $clog2(LDEPTH);
    localparam int unsigned PW1 = PW + 1;

    localparam logic [3:0] OP_INC   = 4'd1;
    localparam logic [3:0] OP_DEC   = 4'd2;
    localparam logic [3:0] OP_RIGHT = 4'd3;
    localparam logic [3:0] OP_LEFT  = 4'd4;
    localparam logic [3:0] OP_OPEN  = 4'd5;
    localparam logic [3:0] OP_CLOSE = 4'd6;
    localparam logic [3:0] OP_OUT   = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_READ, S_WRITE, S_OUT, S_SCAN, S_HALT
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pc, pc_n, nest, nest_n;
    logic [AW-1:0] head, head_n;
    logic [SW-1:0] sp, sp_n;
    logic [DW-1:0] wdata, wdata_n, odata, odata_n, cell_inc, cell_dec;
    logic          we, we_n, oval, oval_n, done, done_n, err, err_n;
    logic          push, adv, fault, cell_nz;
    logic [PW:0]   pc_inc;
    logic [3:0]    opcode;
    logic [PW-1:0] stack [LDEPTH];
    logic [PW-1:0] stack_top;
    logic          unused_bits;

    assign opcode      = instr_i[3:0];
    assign unused_bits = ^instr_i[8:4];
    assign pc_inc      = {1'b0, pc} + PW1'(1);
    assign cell_nz     = (mem_rdata_i != '0);
    assign stack_top   = stack[SIW'(sp - SW'(1))];

`ifdef BF_CELL_SAT_EN
    assign cell_inc = (mem_rdata_i == {DW{1'b1}}) ? mem_rdata_i : mem_rdata_i + DW'(1);
    assign cell_dec = (mem_rdata_i == '0) ? mem_rdata_i : mem_rdata_i - DW'(1);
`else
    assign cell_inc = mem_rdata_i + DW'(1);
    assign cell_dec = mem_rdata_i - DW'(1);
`endif

    // Loop return addresses; validity is tracked solely by sp.
    always_ff @(posedge clk) begin
        if (push) stack[SIW'(sp)] <= pc_inc[PW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= '0;
            head  <= '0;
            sp    <= '0;
            nest  <= '0;
            we    <= 1'b0;
            wdata <= '0;
            oval  <= 1'b0;
            odata <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            head  <= head_n;
            sp    <= sp_n;
            nest  <= nest_n;
            we    <= we_n;
            wdata <= wdata_n;
            oval  <= oval_n;
            odata <= odata_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    // Next state; adv requests PC+1, whose overflow (like stack faults) forces HALT with error.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        head_n  = head;
        sp_n    = sp;
        nest_n  = nest;
        we_n    = 1'b0;
        wdata_n = wdata;
        oval_n  = 1'b0;
        odata_n = odata;
        done_n  = done;
        err_n   = err;
        push    = 1'b0;
        adv     = 1'b0;
        fault   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_n = S_DECODE;
                    pc_n    = '0;
                    head_n  = '0;
                    sp_n    = '0;
                    nest_n  = '0;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_INC, OP_DEC, OP_OPEN, OP_CLOSE, OP_OUT: state_n = S_READ;
                    OP_HALT: begin
                        state_n = S_HALT;
                        done_n  = 1'b1;
                    end
                    OP_RIGHT: begin head_n = head + AW'(1); adv = 1'b1; end
                    OP_LEFT:  begin head_n = head - AW'(1); adv = 1'b1; end
                    default:  adv = 1'b1;
                endcase
            end
            S_READ: begin
                state_n = S_DECODE;
                case (opcode)
                    OP_INC: begin wdata_n = cell_inc; we_n = 1'b1; state_n = S_WRITE; end
                    OP_DEC: begin wdata_n = cell_dec; we_n = 1'b1; state_n = S_WRITE; end
                    OP_OPEN: begin
                        if (!cell_nz) begin
                            nest_n  = PW'(1);
                            adv     = 1'b1;
                            state_n = S_SCAN;
                        end else if (sp == SW'(LDEPTH)) begin
                            fault = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + SW'(1);
                            adv  = 1'b1;
                        end
                    end
                    OP_CLOSE: begin
                        if (sp == '0)   fault = 1'b1;
                        else if (cell_nz) pc_n = stack_top;
                        else begin
                            sp_n = sp - SW'(1);
                            adv  = 1'b1;
                        end
                    end
                    OP_OUT: begin odata_n = mem_rdata_i; oval_n = 1'b1; state_n = S_OUT; end
                    default: ;
                endcase
            end
            S_WRITE: begin
                adv     = 1'b1;
                state_n = S_DECODE;
            end
            S_OUT: begin
                if (out_ready_i) begin
                    adv     = 1'b1;
                    state_n = S_DECODE;
                end else begin
                    oval_n = 1'b1;
                end
            end
            S_SCAN: begin
                adv = 1'b1;
                if (opcode == OP_OPEN) nest_n = nest + PW'(1);
                else if (opcode == OP_CLOSE) begin
                    nest_n = nest - PW'(1);
                    if (nest == PW'(1)) state_n = S_DECODE;
                end
            end
            S_HALT:  ;
            default: state_n = S_IDLE;
        endcase
        if (adv) begin
            if (pc_inc[PW]) fault = 1'b1;
            else            pc_n  = pc_inc[PW-1:0];
        end
        if (fault) begin
            err_n   = 1'b1;
            done_n  = 1'b1;
            state_n = S_HALT;
            we_n    = 1'b0;
            oval_n  = 1'b0;
            push    = 1'b0;
        end
    end

    assign pc_o        = pc;
    assign mem_addr_o  = head;
    assign mem_we_o    = we;
    assign mem_wdata_o = wdata;
    assign out_valid_o = oval;
    assign out_data_o  = odata;
    assign done_o      = done;
    assign error_o     = err;
endmodule

// File: tb/tb_bf_exec_core.sv
// Directed bench for bf_exec_core: program table plus reset/restart sequences.
module tb_bf_exec_core;
    localparam int BUDGET = 3000;
`ifdef BF_CELL_SAT_EN
    localparam logic [7:0] DEC_ZERO = 8'h00;
`else
    localparam logic [7:0] DEC_ZERO = 8'hFF;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] pc_o;
    logic [8:0] instr_i;
    logic [7:0] mem_addr_o;
    logic [7:0] mem_rdata_i;
    logic       mem_we_o;
    logic [7:0] mem_wdata_o;
    logic       out_valid_o;
    logic       out_ready_i = 1'b1;
    logic [7:0] out_data_o;
    logic       done_o;
    logic       error_o;
    logic       mem_clr = 1'b0;

    logic [8:0] rom [256];
    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      prog;
        logic [4:0] hi;
        int         hold;
        int         xfers;
        logic [7:0] first;
        logic [7:0] last;
        logic       err;
        int         pc;
        int         writes;
        logic [7:0] cell0;
    } vec_t;

    vec_t vecs [10];

    bf_exec_core #(.DW(8), .AW(8), .PW(8), .LDEPTH(2)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .pc_o(pc_o), .instr_i(instr_i),
        .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    assign instr_i = rom[pc_o];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_we_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
        end
        mem_rdata_i <= mem[mem_addr_o];
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string p, input logic [4:0] hi, input int hold,
                                input int xf, input logic [7:0] f, input logic [7:0] l,
                                input logic e, input int pc, input int wr, input logic [7:0] c0);
        vec_t v;
        v.prog = p; v.hi = hi; v.hold = hold; v.xfers = xf; v.first = f; v.last = l;
        v.err = e; v.pc = pc; v.writes = wr; v.cell0 = c0;
        return v;
    endfunction

    function automatic logic [3:0] hexval(input byte c);
        if (c >= 8'h61) return 4'(c - 8'h61 + 8'd10);
        return 4'(c - 8'h30);
    endfunction

    task automatic load_rom(input string p, input logic [4:0] hi);
        for (int i = 0; i < 256; i++) rom[i] = 9'h000;
        for (int i = 0; i < p.len(); i++) rom[i] = {hi, hexval(p[i])};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start_i = 1'b0;
        out_ready_i = 1'b1;
        mem_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0, xf = 0, wr = 0, hold = 0, unstable = 0;
        logic [7:0] first = 8'h00, last = 8'h00;
        load_rom(v.prog, v.hi);
        do_reset();
        pulse_start();
        while (done_o !== 1'b1 && cyc < BUDGET) begin
            if (mem_we_o) wr++;
            if (out_valid_o) begin
                if (hold < v.hold) begin
                    out_ready_i = 1'b0;
                    if (out_data_o !== v.first) unstable++;
                    hold++;
                end else begin
                    out_ready_i = 1'b1;
                    if (xf == 0) first = out_data_o;
                    last = out_data_o;
                    xf++;
                end
            end else begin
                out_ready_i = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d_in_budget", idx), int'(cyc < BUDGET), 1);
        check($sformatf("v%0d_done", idx), int'(done_o), 1);
        check($sformatf("v%0d_error", idx), int'(error_o), int'(v.err));
        check($sformatf("v%0d_pc", idx), int'(pc_o), v.pc);
        check($sformatf("v%0d_xfers", idx), xf, v.xfers);
        check($sformatf("v%0d_first_out", idx), int'(first), int'(v.first));
        check($sformatf("v%0d_last_out", idx), int'(last), int'(v.last));
        check($sformatf("v%0d_writes", idx), wr, v.writes);
        check($sformatf("v%0d_cell0", idx), int'(mem[0]), int'(v.cell0));
        if (v.hold > 0) begin
            check($sformatf("v%0d_hold_cycles", idx), hold, v.hold);
            check($sformatf("v%0d_hold_stable", idx), unstable, 0);
        end
    endtask

    initial begin
        int cyc;
        int wr;
        // Opcodes: 0 NOP 1 INC 2 DEC 3 RIGHT 4 LEFT 5 OPEN 6 CLOSE 7 OUT 8 HALT
        vecs[0] = mk("11178",        5'h00, 0, 1, 8'd3, 8'd3, 1'b0, 4,   3, 8'd3);
        vecs[1] = mk("111531426378", 5'h00, 0, 1, 8'd3, 8'd3, 1'b0, 11,  9, 8'd0);
        vecs[2] = mk("5156678",      5'h00, 0, 1, 8'd0, 8'd0, 1'b0, 6,   0, 8'd0);
        vecs[3] = mk("15558",        5'h00, 0, 0, 8'd0, 8'd0, 1'b1, 3,   1, 8'd1);
        vecs[4] = mk("278",          5'h00, 5, 1, DEC_ZERO, DEC_ZERO, 1'b0, 2, 1, DEC_ZERO);
        vecs[5] = mk("6",            5'h00, 0, 0, 8'd0, 8'd0, 1'b1, 0,   0, 8'd0);
        vecs[6] = mk("9af1d1e78",    5'h1f, 0, 1, 8'd2, 8'd2, 1'b0, 8,   2, 8'd2);
        vecs[7] = mk("417378",       5'h00, 0, 2, 8'd1, 8'd0, 1'b0, 5,   1, 8'd0);
        vecs[8] = mk("",             5'h00, 0, 0, 8'd0, 8'd0, 1'b1, 255, 0, 8'd0);
        vecs[9] = mk("115311426378", 5'h00, 0, 1, 8'd4, 8'd4, 1'b0, 11,  8, 8'd0);

        // Reset values while reset is held low
        mem_clr = 1'b1;
        #1;
        check("rst_pc", int'(pc_o), 0);
        check("rst_addr", int'(mem_addr_o), 0);
        check("rst_we", int'(mem_we_o), 0);
        check("rst_wdata", int'(mem_wdata_o), 0);
        check("rst_valid", int'(out_valid_o), 0);
        check("rst_odata", int'(out_data_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_error", int'(error_o), 0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset asserted during the WRITE cycle of INC aborts the write
        load_rom("18", 5'h00);
        do_reset();
        pulse_start();
        cyc = 0;
        while (mem_we_o !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("wr_we_seen", int'(mem_we_o), 1);
        reset = 1'b0;
        #1;
        check("wr_rst_we", int'(mem_we_o), 0);
        check("wr_rst_pc", int'(pc_o), 0);
        check("wr_rst_done", int'(done_o), 0);
        @(negedge clk);
        reset = 1'b1;
        wr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_we_o) wr++;
        end
        check("wr_no_write", int'(mem[0]), 0);
        check("idle_writes", wr, 0);
        check("idle_pc", int'(pc_o), 0);
        check("idle_done", int'(done_o), 0);
        pulse_start();
        cyc = 0;
        while (done_o !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("restart_done", int'(done_o), 1);
        check("restart_cell0", int'(mem[0]), 1);
        check("restart_pc", int'(pc_o), 1);
        check("restart_error", int'(error_o), 0);

        // start_i is ignored once halted
        pulse_start();
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("halt_start_done", int'(done_o), 1);
        check("halt_start_pc", int'(pc_o), 1);
        check("halt_start_cell0", int'(mem[0]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
